decoder: RTL and testbench



---
 rtl/decoder.sv | 92 +++++++++
 tb/tb_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// rtl/decoder.sv - serial frame receiver: start, 8 data LSB first, parity, stop
module decoder #(
  parameter bit ODD_PARITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       d,
  input  logic       rd_en,
  output logic [7:0] q,
  output logic       rdy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       ovr,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] bit_cnt;
  logic [8:0] shift_reg;
  logic       complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    if (clk_en) begin
      case (state)
        IDLE:      if (!d) state_nxt = DATA;
        DATA:      if (bit_cnt == 4'd8) state_nxt = STOP;
        STOP: begin
          complete  = 1'b1;
          // a low stop bit must see the line return high before a new start counts
          state_nxt = d ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: if (d) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state == DATA) || (state == STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 4'd0;
      shift_reg  <= 9'd0;
      q          <= 8'd0;
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      if (clk_en) begin
        if (state == IDLE && !d) begin
          bit_cnt <= 4'd0;
        end else if (state == DATA) begin
          // shift right so the first data bit ends in bit 0 and parity in bit 8
          shift_reg <= {d, shift_reg[8:1]};
          bit_cnt   <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
        end
      end

      if (complete) begin
        q          <= shift_reg[7:0];
        parity_err <= (^shift_reg) ^ ODD_PARITY;
        frame_err  <= ~d;
        rdy        <= 1'b1;
        ovr        <= rdy & ~rd_en;
      end else if (rd_en && rdy) begin
        rdy <= 1'b0;
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - self-checking bench for the serial frame decoder
module tb_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       d = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] q;
  logic       rdy, parity_err, frame_err, ovr, busy;

  int tests = 0;
  int fails = 0;

  decoder #(.ODD_PARITY(1'b1)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .d(d), .rd_en(rd_en),
    .q(q), .rdy(rdy), .parity_err(parity_err), .frame_err(frame_err),
    .ovr(ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       flip_par;
    logic       rd_on_stop;
    logic       rd_after;
    logic [7:0] exp_q;
    logic       exp_rdy;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one bit period: gap idle clocks, then one clk_en edge sampling b; returns at negedge
  task automatic strobe(input logic b, input int gap, input logic rd);
    repeat (gap) begin
      @(negedge clk);
      clk_en = 1'b0;
      d = b;
    end
    @(negedge clk);
    clk_en = 1'b1;
    d = b;
    rd_en = rd;
    @(negedge clk);
    clk_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic flip, input logic stop,
                            input logic rd_on_stop, input int gmax);
    logic [10:0] bits;
    logic        par;
    par  = ~(^data) ^ flip;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      strobe(bits[i], $urandom_range(gmax, 0), (i == 10) && rd_on_stop);
      if (i == 0) chk("busy_start", busy, 1'b1);
    end
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic er,
                         input logic ep, input logic ef, input logic eo, input logic eb);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_rdy"}, rdy, er);
    chk({tag, "_perr"}, parity_err, ep);
    chk({tag, "_ferr"}, frame_err, ef);
    chk({tag, "_ovr"}, ovr, eo);
    chk({tag, "_busy"}, busy, eb);
  endtask

  logic [7:0] exp_q[$];
  logic       m_rdy, m_ovr;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h12, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h34, 1'b0, 1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h12, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h34, 1'b0, 1'b1, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    strobe(1'b1, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].flip_par, 1'b1, vecs[i].rd_on_stop, 2);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_rdy,
              vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_ovr, 1'b0);
      if (vecs[i].rd_after) begin
        rd_pulse();
        chk($sformatf("vec%0d_rd_rdy", i), rdy, 1'b0);
        chk($sformatf("vec%0d_rd_ovr", i), ovr, 1'b0);
      end
    end

    // low stop bit, line held low, then a clean frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1);
    chk_all("stop_low", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rd_pulse();
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, 1, 1'b0);
      chk("wait_low_rdy", rdy, 1'b0);
      chk("wait_low_busy", busy, 1'b0);
    end
    strobe(1'b1, 0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1);
    chk_all("after_low", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-frame after data bit 4 of 0xFF
    strobe(1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    clk_en = 1'b1;
    d = 1'b1;
    @(negedge clk);
    chk_all("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clk_en = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1);
    chk_all("post_rst", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_pulse();

    // random end-to-end against a frame-level model
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic       flip, rd_stop, rd_aft, exp_perr;
      logic [7:0] eq;
      b       = 8'($urandom);
      flip    = ($urandom_range(3, 0) == 0);
      rd_stop = ($urandom_range(3, 0) == 0);
      rd_aft  = $urandom_range(1, 0) == 1;
      exp_q.push_back(b);
      exp_perr = ($countones({~(^b) ^ flip, b}) % 2) == 0;
      repeat ($urandom_range(2, 0)) strobe(1'b1, $urandom_range(3, 0), 1'b0);
      send_frame(b, flip, 1'b1, rd_stop, 3);
      m_ovr = m_rdy & ~rd_stop;
      m_rdy = 1'b1;
      eq = exp_q.pop_front();
      chk_all($sformatf("rnd%0d", n), eq, m_rdy, exp_perr, 1'b0, m_ovr, 1'b0);
      if (rd_aft) begin
        rd_pulse();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        chk($sformatf("rnd%0d_rd", n), {rdy, ovr}, {m_rdy, m_ovr});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
